mem_bus_ctrl: RTL and testbench

//   Next-generation external memory/I-O controller between the multicycle MIPS controller and storage.

---
 rtl/mem_bus_ctrl.sv | 178 +++++++++++++++++
 tb/tb_mem_bus_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// External memory / I-O controller: decodes ROM, RAM and memory-mapped I/O behind a
// req/ready handshake with programmable wait states and access-error reporting.
module mem_bus_ctrl #(
  parameter int WIDTH       = 32,
  parameter int ADDR_WIDTH  = 16,
  parameter int RAM_AW      = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [1:0]            size,
  input  logic                  sext,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [WIDTH-1:0]      wdata,
  output logic [RAM_AW-1:0]     rom_addr,
  input  logic [WIDTH-1:0]      rom_data,
  input  logic [15:0]           switches,
  output logic [15:0]           leds,
  output logic [WIDTH-1:0]      rdata,
  output logic                  ready,
  output logic                  err
);
  localparam logic [1:0] SZ_WORD   = 2'b00;
  localparam logic [1:0] SZ_HALF   = 2'b01;
  localparam logic [1:0] SZ_BYTE   = 2'b10;
  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                state_reg;
  logic [3:0]            wait_cnt_reg;
  logic                  we_reg, sext_reg;
  logic [1:0]            size_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [WIDTH-1:0]      wdata_reg;
  logic [31:0]           counter_reg, counter_next;
  logic [15:0]           sw_meta_reg, sw_sync_reg;
  logic [WIDTH-1:0]      ram [2**RAM_AW];

  logic                  cur_we, cur_sext;
  logic [1:0]            cur_size;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [WIDTH-1:0]      cur_wdata;
  logic                  commit, ram_we, bad, sw_read;
  logic                  is_rom, is_ram, is_cnt, is_io;
  logic [RAM_AW-1:0]     word_idx;
  logic [WIDTH-1:0]      src_word, load_word, wide_wdata;
  logic [15:0]           half_sel;
  logic [7:0]            byte_sel;
  logic [3:0]            lane_en;

  // With no wait states the access commits on the accept edge, so the live bus fields are used.
  always_comb begin
    cur_we    = (WAIT_STATES == 0) ? we    : we_reg;
    cur_sext  = (WAIT_STATES == 0) ? sext  : sext_reg;
    cur_size  = (WAIT_STATES == 0) ? size  : size_reg;
    cur_addr  = (WAIT_STATES == 0) ? addr  : addr_reg;
    cur_wdata = (WAIT_STATES == 0) ? wdata : wdata_reg;
  end

  assign word_idx     = cur_addr[RAM_AW+1:2];
  assign rom_addr     = word_idx;
  assign counter_next = counter_reg + 32'd1;
  assign commit = reset && ((state_reg == S_WAIT && wait_cnt_reg == 4'd0) ||
                            (WAIT_STATES == 0 && state_reg == S_IDLE && req));

  always_comb begin
    is_rom  = cur_addr[15:12] == 4'h0;
    is_ram  = cur_addr[15:12] == 4'h1;
    is_cnt  = cur_addr == 16'hFFF0;
    is_io   = cur_addr[15:2] == 14'h3FFF;
    sw_read = is_io && cur_addr[1];
    bad     = 1'b0;
    case (cur_size)
      SZ_WORD: bad = cur_addr[1:0] != 2'b00;
      SZ_HALF: bad = cur_addr[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    if (!(is_rom || is_ram || is_cnt || is_io)) bad = 1'b1;
    if (is_rom && cur_we)                        bad = 1'b1;
    if (is_io && cur_size != SZ_BYTE)            bad = 1'b1;
    if (is_cnt && cur_size != SZ_WORD)           bad = 1'b1;
    if (sw_read && cur_we)                       bad = 1'b1;
  end

  always_comb begin
    if (is_rom)      src_word = rom_data;
    else if (is_ram) src_word = ram[word_idx];
    else if (is_cnt) src_word = counter_next;
    else             src_word = {sw_sync_reg, leds};
    half_sel = cur_addr[1] ? src_word[31:16] : src_word[15:0];
    byte_sel = src_word[{cur_addr[1:0], 3'b000} +: 8];
    case (cur_size)
      SZ_HALF: load_word = {{16{cur_sext & half_sel[15]}}, half_sel};
      SZ_BYTE: load_word = {{24{cur_sext & ~sw_read & byte_sel[7]}}, byte_sel};
      default: load_word = src_word;
    endcase
  end

  // Right-aligned store data is replicated across lanes; lane_en picks the bytes to write.
  always_comb begin
    case (cur_size)
      SZ_WORD: begin lane_en = 4'hF; wide_wdata = cur_wdata; end
      SZ_HALF: begin
        lane_en    = cur_addr[1] ? 4'hC : 4'h3;
        wide_wdata = {2{cur_wdata[15:0]}};
      end
      SZ_BYTE: begin
        lane_en    = 4'b0001 << cur_addr[1:0];
        wide_wdata = {4{cur_wdata[7:0]}};
      end
      default: begin lane_en = 4'h0; wide_wdata = cur_wdata; end
    endcase
  end

  assign ram_we = commit && !bad && cur_we && is_ram;

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) ram[word_idx][8*i +: 8] <= wide_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      we_reg       <= 1'b0;
      sext_reg     <= 1'b0;
      size_reg     <= 2'b00;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      counter_reg  <= 32'd0;
      sw_meta_reg  <= 16'd0;
      sw_sync_reg  <= 16'd0;
      leds         <= 16'd0;
      rdata        <= '0;
      ready        <= 1'b0;
      err          <= 1'b0;
    end else begin
      sw_meta_reg <= switches;
      sw_sync_reg <= sw_meta_reg;
      counter_reg <= counter_next;
      ready       <= 1'b0;
      case (state_reg)
        S_IDLE: if (req) begin
          we_reg       <= we;
          sext_reg     <= sext;
          size_reg     <= size;
          addr_reg     <= addr;
          wdata_reg    <= wdata;
          wait_cnt_reg <= WAIT_LOAD;
          state_reg    <= (WAIT_STATES == 0) ? S_DONE : S_WAIT;
        end
        S_WAIT: begin
          if (wait_cnt_reg == 4'd0) state_reg <= S_DONE;
          else                      wait_cnt_reg <= wait_cnt_reg - 4'd1;
        end
        default: state_reg <= S_IDLE;
      endcase
      if (commit) begin
        ready <= 1'b1;
        err   <= bad;
        rdata <= (bad || cur_we) ? '0 : load_word;
        if (!bad && cur_we && is_io) begin
          if (cur_addr[0]) leds[15:8] <= cur_wdata[7:0];
          else             leds[7:0]  <= cur_wdata[7:0];
        end
        if (!bad && cur_we && is_cnt) counter_reg <= 32'd0;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed plus randomized bench for mem_bus_ctrl against a byte-level memory/I-O model.
module tb_mem_bus_ctrl;
  localparam int WS = 1;

  logic        clk = 1'b0, reset = 1'b0, req = 1'b0, we = 1'b0, sext = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [15:0] addr = 16'h0;
  logic [31:0] wdata = 32'h0;
  logic [9:0]  rom_addr;
  logic [31:0] rom_data, rdata;
  logic [15:0] switches = 16'h0, leds;
  logic        ready, err;

  int          n_checks = 0, n_fail = 0;
  logic [31:0] edge_no = 32'd0, base = 32'd0;
  logic [7:0]  mem_b [int];
  logic [15:0] leds_m = 16'h0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_no <= edge_no + 32'd1;

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return {~a[7:0], a[7:0] ^ 8'h3C, 6'd0, a[9:8], a[7:0] + 8'h81};
  endfunction
  assign rom_data = rom_word(rom_addr);

  mem_bus_ctrl #(.WIDTH(32), .ADDR_WIDTH(16), .RAM_AW(10), .WAIT_STATES(WS)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .sext(sext), .addr(addr),
    .wdata(wdata), .rom_addr(rom_addr), .rom_data(rom_data), .switches(switches),
    .leds(leds), .rdata(rdata), .ready(ready), .err(err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic w, input logic [1:0] sz, input logic [15:0] a);
    int lanes;
    logic rom, ram, cnt, io;
    lanes = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    rom = a < 16'h1000;
    ram = a >= 16'h1000 && a < 16'h2000;
    cnt = a == 16'hFFF0;
    io  = a >= 16'hFFFC;
    if (sz == 2'b11) return 1'b1;
    if (int'(a) % lanes != 0) return 1'b1;
    if (!(rom || ram || cnt || io)) return 1'b1;
    if (rom && w) return 1'b1;
    if (io && lanes != 1) return 1'b1;
    if (cnt && lanes != 4) return 1'b1;
    if (io && w && a >= 16'hFFFE) return 1'b1;
    return 1'b0;
  endfunction

  // {known, value} of one byte as the address map defines it
  function automatic logic [8:0] byte_at(input logic [15:0] a);
    logic [31:0] w;
    if (a < 16'h1000) begin
      w = rom_word(a[11:2]);
      return {1'b1, 8'(w >> (8 * int'(a[1:0])))};
    end
    if (a < 16'h2000) return mem_b.exists(int'(a)) ? {1'b1, mem_b[int'(a)]} : 9'h0;
    case (a)
      16'hFFFC: return {1'b1, leds_m[7:0]};
      16'hFFFD: return {1'b1, leds_m[15:8]};
      16'hFFFE: return {1'b1, switches[7:0]};
      default:  return {1'b1, switches[15:8]};
    endcase
  endfunction

  task automatic xact(input logic w, input logic [1:0] sz, input logic sx, input logic [15:0] a,
                      input logic [31:0] d, input string tag);
    logic        e_err, known, got;
    logic [31:0] e_rd;
    logic [8:0]  b;
    logic [15:0] ai;
    logic [7:0]  bv;
    int          lanes, n;
    e_err = model_err(w, sz, a);
    e_rd  = 32'd0;
    known = 1'b1;
    lanes = (sz == 2'd0) ? 4 : (sz == 2'd1) ? 2 : 1;
    if (!e_err && !w && a != 16'hFFF0) begin
      for (int i = 0; i < lanes; i++) begin
        b = byte_at(a + 16'(i));
        known &= b[8];
        e_rd |= 32'(b[7:0]) << (8 * i);
      end
      if (sx && a < 16'hFFFE) begin
        if (lanes == 1 && e_rd[7])  e_rd |= 32'hFFFF_FF00;
        if (lanes == 2 && e_rd[15]) e_rd |= 32'hFFFF_0000;
      end
    end
    if (!e_err && w) begin
      for (int i = 0; i < lanes; i++) begin
        ai = a + 16'(i);
        bv = 8'(d >> (8 * i));
        if (ai >= 16'h1000 && ai < 16'h2000) mem_b[int'(ai)] = bv;
        else if (ai == 16'hFFFC) leds_m[7:0] = bv;
        else if (ai == 16'hFFFD) leds_m[15:8] = bv;
      end
    end
    we = w; size = sz; sext = sx; addr = a; wdata = d; req = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk); n++; #1;
      got = ready;
    end
    check({tag, " ready"}, 32'(got), 32'd1);
    check({tag, " latency"}, 32'(n), 32'(WS + 1));
    check({tag, " err"}, 32'(err), 32'(e_err));
    if (!e_err && w && a == 16'hFFF0) base = edge_no;
    if (!e_err && !w && a == 16'hFFF0) e_rd = edge_no - base;
    if (e_err || (!w && known)) check({tag, " rdata"}, rdata, e_rd);
    req = 1'b0;
    @(posedge clk); #1;
    check({tag, " ready pulse"}, 32'(ready), 32'd0);
    $display("xact %-12s we=%0d size=%0d sext=%0d addr=%h wdata=%h -> err=%0d rdata=%h exp_err=%0d exp_rdata=%h",
             tag, w, sz, sx, a, d, err, rdata, e_err, e_rd);
  endtask

  initial begin
    logic        got;
    logic [15:0] ra;
    int          cat;
    switches = 16'hC3A5;
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(ready), 32'd0);
    check("reset err", 32'(err), 32'd0);
    check("reset rdata", rdata, 32'd0);
    check("reset leds", 32'(leds), 32'd0);
    @(negedge clk); reset = 1'b1; base = edge_no;
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) xact(1'b1, 2'd0, 1'b0, 16'h1000 + 16'(4 * i), $urandom, "fill");

    xact(1'b1, 2'd0, 1'b0, 16'h1004, 32'hDEADBEEF, "st word");
    xact(1'b1, 2'd2, 1'b0, 16'h1006, 32'h0000_0055, "st byte");
    xact(1'b0, 2'd0, 1'b0, 16'h1004, 32'h0, "ld merged");
    check("merged const", rdata, 32'hDE55BEEF);

    xact(1'b1, 2'd0, 1'b0, 16'h1008, 32'h80F07F81, "st 1008");
    xact(1'b0, 2'd2, 1'b1, 16'h1008, 32'h0, "ld sbyte");
    check("sbyte const", rdata, 32'hFFFFFF81);
    xact(1'b0, 2'd1, 1'b0, 16'h100A, 32'h0, "ld uhalf");
    check("uhalf const", rdata, 32'h000080F0);

    xact(1'b0, 2'd1, 1'b0, 16'h1001, 32'h0, "mis half");
    xact(1'b0, 2'd0, 1'b0, 16'h1002, 32'h0, "mis word");
    xact(1'b1, 2'd0, 1'b0, 16'h0010, 32'h12345678, "st rom");
    xact(1'b0, 2'd0, 1'b0, 16'h2000, 32'h0, "unmapped");
    xact(1'b1, 2'd0, 1'b0, 16'h1005, 32'h01020304, "mis st");
    xact(1'b1, 2'd3, 1'b0, 16'h1004, 32'h01020304, "size11");
    xact(1'b0, 2'd0, 1'b0, 16'h1004, 32'h0, "ld unchanged");
    xact(1'b0, 2'd0, 1'b0, 16'h0024, 32'h0, "ld rom");

    xact(1'b1, 2'd2, 1'b0, 16'hFFFC, 32'h34, "led lo");
    xact(1'b1, 2'd2, 1'b0, 16'hFFFD, 32'h12, "led hi");
    check("leds 1234", 32'(leds), 32'h1234);
    xact(1'b1, 2'd2, 1'b0, 16'hFFFD, 32'hAB, "led hi2");
    check("leds AB34", 32'(leds), 32'hAB34);
    xact(1'b1, 2'd1, 1'b0, 16'hFFFC, 32'h5555, "led half");
    xact(1'b1, 2'd2, 1'b0, 16'hFFFE, 32'h77, "st sw");
    check("leds kept", 32'(leds), 32'(leds_m));
    repeat (3) @(posedge clk);
    #1;
    xact(1'b0, 2'd2, 1'b1, 16'hFFFE, 32'h0, "sw lo");
    check("sw lo const", rdata, 32'h000000A5);
    xact(1'b0, 2'd2, 1'b1, 16'hFFFF, 32'h0, "sw hi");
    check("sw hi const", rdata, 32'h000000C3);
    xact(1'b0, 2'd2, 1'b1, 16'hFFFD, 32'h0, "led rd");

    // abort a RAM store with reset while it waits
    we = 1'b1; size = 2'd0; sext = 1'b0; addr = 16'h1010; wdata = 32'hCAFEF00D; req = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    leds_m = 16'h0;
    check("abort leds", 32'(leds), 32'd0);
    check("abort ready", 32'(ready), 32'd0);
    got = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      if (ready) got = 1'b1;
    end
    check("abort no ready", 32'(got), 32'd0);
    req = 1'b0;
    @(negedge clk); reset = 1'b1; base = edge_no;
    @(posedge clk); #1;
    xact(1'b0, 2'd0, 1'b0, 16'hFFF0, 32'h0, "cnt reset");
    xact(1'b0, 2'd0, 1'b0, 16'h1010, 32'h0, "abort ram");

    xact(1'b1, 2'd0, 1'b0, 16'hFFF0, 32'h12345678, "cnt clear");
    repeat (4) @(posedge clk);
    #1;
    xact(1'b0, 2'd0, 1'b0, 16'hFFF0, 32'h0, "cnt read");
    check("cnt read const", rdata, 32'd7);
    xact(1'b0, 2'd1, 1'b0, 16'hFFF0, 32'h0, "cnt half");
    force dut.counter_reg = 32'hFFFF_FFFF;
    #1 release dut.counter_reg;
    base = edge_no + 32'd1;
    xact(1'b0, 2'd0, 1'b0, 16'hFFF0, 32'h0, "cnt wrap");

    for (int i = 0; i < 150; i++) begin
      cat = $urandom_range(0, 9);
      case (cat)
        6:       ra = 16'($urandom_range(0, 16'h0FFF));
        7:       ra = 16'hFFFC + 16'($urandom_range(0, 3));
        8:       ra = 16'($urandom_range(16'h2000, 16'hFFEF));
        9:       ra = 16'hFFF1 + 16'($urandom_range(0, 10));
        default: ra = 16'h1000 + 16'($urandom_range(0, 63));
      endcase
      xact(1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
           1'($urandom_range(0, 1)), ra, $urandom, "random");
    end
    check("final leds", 32'(leds), 32'(leds_m));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
